moore_seq_detector: RTL and testbench

//  Parametrised Moore-type sequence detector: the generalised successor of the fixed 2-bit no_moore FSM.

---
 rtl/moore_seq_detector.sv | 119 +++++++++++
 tb/tb_moore_seq_detector.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detector.sv
// Moore detector for an N-symbol pattern of W-bit symbols (KMP automaton).
// Ports: clk, rst (async active-low), clr, en, a -> match, progress, match_cnt.
module moore_seq_detector #(
  parameter int unsigned    W       = 2,
  parameter int unsigned    N       = 4,
  parameter logic [N*W-1:0] PATTERN = 8'b01_10_01_10,
  parameter bit             OVERLAP = 1'b1,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic [W-1:0]             a,
  output logic                     match,
  output logic [$clog2(N+1)-1:0]   progress,
  output logic [CNT_W-1:0]         match_cnt
);

  localparam int unsigned SW = $clog2(N + 1);
  localparam int unsigned IW = SW + W;
  localparam int unsigned TN = 1 << IW;

  typedef logic [TN-1:0][SW-1:0] tbl_t;

  localparam logic [SW-1:0] FULL = SW'(N);

  // symbol i of the pattern, symbol 0 in the MSBs
  function automatic logic [W-1:0] sym(
    input int unsigned i
  );
    return PATTERN[(N-1-i)*W +: W];
  endfunction

  // longest proper border of the full pattern
  function automatic int unsigned border();
    int unsigned b;
    logic        ok;
    b = 0;
    for (int unsigned k = 1; k < N; k++) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < k; j++)
        if (sym(N - k + j) != sym(j)) ok = 1'b0;
      if (ok) b = k;
    end
    return b;
  endfunction

  // longest pattern prefix that is a suffix of
  // (matched prefix of length e) followed by x
  function automatic int unsigned adv(
    input int unsigned s,
    input logic [W-1:0] x
  );
    int unsigned e;
    int unsigned r;
    logic        ok;
    if (s == N) e = OVERLAP ? border() : 0;
    else        e = s;
    r = 0;
    for (int unsigned k = 1; k <= e + 1; k++) begin
      ok = (x == sym(k - 1));
      for (int unsigned j = 0; j + 1 < k; j++)
        if (sym(e + 1 - k + j) != sym(j)) ok = 1'b0;
      if (ok) r = k;
    end
    return r;
  endfunction

  // full next-state table indexed by {state, symbol};
  // unreachable states (> N) map to 0
  function automatic tbl_t build();
    tbl_t t;
    t = '0;
    for (int unsigned s = 0; s < (1 << SW); s++)
      for (int unsigned x = 0; x < (1 << W); x++)
        if (s <= N)
          t[(s << W) | x] = SW'(adv(s, W'(x)));
    return t;
  endfunction

  localparam tbl_t NXT = build();

  logic [SW-1:0]    state;
  logic [SW-1:0]    state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (clr) begin
      state_nx = '0;
      cnt_nx   = '0;
    end else if (en) begin
      state_nx = NXT[{state, a}];
      // counter saturates at all-ones
      if (state_nx == FULL && cnt != '1)
        cnt_nx = cnt + 1'b1;
    end
  end

  always_comb begin
    match     = (state == FULL);
    progress  = state;
    match_cnt = cnt;
  end

endmodule

// File: tb/tb_moore_seq_detector.sv
// Testbench for moore_seq_detector: overlap, non-overlap, saturating and
// repeated-symbol instances against a prefix-search reference model.
module tb_moore_seq_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       en  = 1'b0;
  logic [1:0] a   = 2'b00;

  logic       m_ov, m_no, m_sat, m_rep;
  logic [2:0] p_ov, p_no, p_sat;
  logic [1:0] p_rep;
  logic [7:0] c_ov, c_no, c_rep;
  logic [1:0] c_sat;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  moore_seq_detector #(.W(2), .N(4), .PATTERN(8'b01_10_01_10),
    .OVERLAP(1'b1), .CNT_W(8)) d_ov (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .a(a),
    .match(m_ov), .progress(p_ov), .match_cnt(c_ov));

  moore_seq_detector #(.W(2), .N(4), .PATTERN(8'b01_10_01_10),
    .OVERLAP(1'b0), .CNT_W(8)) d_no (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .a(a),
    .match(m_no), .progress(p_no), .match_cnt(c_no));

  moore_seq_detector #(.W(2), .N(4), .PATTERN(8'b01_10_01_10),
    .OVERLAP(1'b1), .CNT_W(2)) d_sat (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .a(a),
    .match(m_sat), .progress(p_sat), .match_cnt(c_sat));

  moore_seq_detector #(.W(2), .N(2), .PATTERN(4'b11_11),
    .OVERLAP(1'b1), .CNT_W(8)) d_rep (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .a(a),
    .match(m_rep), .progress(p_rep), .match_cnt(c_rep));

  // reference model: keep the symbols consumed since the last restart
  // and search for the longest pattern prefix ending the history
  int pat [4][$];
  int hist[4][$];
  int st  [4];
  int cnt [4];
  int cmax[4];
  int ovl [4];

  function automatic int plen(input int h[$], input int p[$]);
    int best;
    bit ok;
    best = 0;
    for (int k = 1; k <= p.size() && k <= h.size(); k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (h[h.size() - k + j] != p[j]) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 4; i++) begin
      hist[i].delete();
      st[i]  = 0;
      cnt[i] = 0;
    end
  endtask

  task automatic madv(input int x);
    for (int i = 0; i < 4; i++) begin
      if (st[i] == pat[i].size() && ovl[i] == 0)
        hist[i].delete();
      hist[i].push_back(x);
      if (hist[i].size() > 16) void'(hist[i].pop_front());
      st[i] = plen(hist[i], pat[i]);
      if (st[i] == pat[i].size() && cnt[i] < cmax[i])
        cnt[i]++;
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_dut(input int i, input int p, input int m,
                         input int c);
    string n;
    n = $sformatf("dut%0d", i);
    chk({n, "_progress"}, p, st[i]);
    chk({n, "_match"}, m, int'(st[i] == pat[i].size()));
    chk({n, "_cnt"}, c, cnt[i]);
  endtask

  task automatic check_all();
    chk_dut(0, int'(p_ov),  int'(m_ov),  int'(c_ov));
    chk_dut(1, int'(p_no),  int'(m_no),  int'(c_no));
    chk_dut(2, int'(p_sat), int'(m_sat), int'(c_sat));
    chk_dut(3, int'(p_rep), int'(m_rep), int'(c_rep));
  endtask

  task automatic step(input bit c, input bit e, input logic [1:0] x);
    @(negedge clk);
    clr = c;
    en  = e;
    a   = x;
    @(posedge clk);
    if (c)      mreset();
    else if (e) madv(int'(x));
    #1;
    check_all();
  endtask

  typedef struct {
    bit         c;
    bit         e;
    logic [1:0] x;
    int         p_ov;
    int         m_ov;
    int         c_ov;
    int         p_no;
    int         c_no;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit c, input bit e, input logic [1:0] x,
                     input int pov, input int mov, input int cov,
                     input int pno, input int cno);
    vec_t v;
    v = '{c, e, x, pov, mov, cov, pno, cno};
    tbl.push_back(v);
  endtask

  initial begin
    pat[0] = '{1, 2, 1, 2};
    pat[1] = '{1, 2, 1, 2};
    pat[2] = '{1, 2, 1, 2};
    pat[3] = '{3, 3};
    cmax   = '{255, 255, 3, 255};
    ovl    = '{1, 0, 1, 1};
    mreset();

    // overlap vs non-overlap, then a second non-overlap match
    add(0, 1, 2'b01, 1, 0, 0, 1, 0);
    add(0, 1, 2'b10, 2, 0, 0, 2, 0);
    add(0, 1, 2'b01, 3, 0, 0, 3, 0);
    add(0, 1, 2'b10, 4, 1, 1, 4, 1);
    add(0, 1, 2'b01, 3, 0, 1, 1, 1);
    add(0, 1, 2'b10, 4, 1, 2, 2, 1);
    add(0, 1, 2'b01, 3, 0, 2, 3, 1);
    add(0, 1, 2'b10, 4, 1, 3, 4, 2);
    add(1, 1, 2'b01, 0, 0, 0, 0, 0);
    // failure-table fallback
    add(0, 1, 2'b01, 1, 0, 0, 1, 0);
    add(0, 1, 2'b10, 2, 0, 0, 2, 0);
    add(0, 1, 2'b01, 3, 0, 0, 3, 0);
    add(0, 1, 2'b01, 1, 0, 0, 1, 0);
    add(0, 1, 2'b10, 2, 0, 0, 2, 0);
    add(0, 1, 2'b01, 3, 0, 0, 3, 0);
    add(0, 1, 2'b10, 4, 1, 1, 4, 1);
    add(1, 1, 2'b01, 0, 0, 0, 0, 0);
    // enable hold
    add(0, 1, 2'b01, 1, 0, 0, 1, 0);
    add(0, 1, 2'b10, 2, 0, 0, 2, 0);
    add(0, 1, 2'b01, 3, 0, 0, 3, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 2'b11, 3, 0, 0, 3, 0);
    add(0, 1, 2'b10, 4, 1, 1, 4, 1);
    add(0, 0, 2'b00, 4, 1, 1, 4, 1);
    add(0, 0, 2'b00, 4, 1, 1, 4, 1);

    // reset state
    #12;
    chk("rst_p_ov", int'(p_ov), 0);
    chk("rst_m_ov", int'(m_ov), 0);
    chk("rst_c_ov", int'(c_ov), 0);
    chk("rst_p_rep", int'(p_rep), 0);
    @(negedge clk);
    #2 rst = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].e, tbl[i].x);
      chk($sformatf("tbl%0d_p_ov", i), int'(p_ov), tbl[i].p_ov);
      chk($sformatf("tbl%0d_m_ov", i), int'(m_ov), tbl[i].m_ov);
      chk($sformatf("tbl%0d_c_ov", i), int'(c_ov), tbl[i].c_ov);
      chk($sformatf("tbl%0d_p_no", i), int'(p_no), tbl[i].p_no);
      chk($sformatf("tbl%0d_m_no", i), int'(m_no),
          int'(tbl[i].p_no == 4));
      chk($sformatf("tbl%0d_c_no", i), int'(c_no), tbl[i].c_no);
    end

    // async reset between edges
    step(1, 0, 2'b00);
    step(0, 1, 2'b01);
    step(0, 1, 2'b10);
    step(0, 1, 2'b01);
    @(negedge clk);
    en = 1'b1;
    a  = 2'b01;
    #2 rst = 1'b0;
    mreset();
    #1;
    chk("arst_p", int'(p_ov), 0);
    chk("arst_m", int'(m_ov), 0);
    chk("arst_c", int'(c_ov), 0);
    @(posedge clk);
    #1;
    chk("arst_hold_p", int'(p_ov), 0);
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    step(0, 1, 2'b01);
    step(0, 1, 2'b10);
    step(0, 1, 2'b01);
    chk("arst_pre_m", int'(m_ov), 0);
    step(0, 1, 2'b10);
    chk("arst_post_m", int'(m_ov), 1);
    chk("arst_post_c", int'(c_ov), 1);

    // saturation and clear
    step(1, 0, 2'b00);
    step(0, 1, 2'b01);
    step(0, 1, 2'b10);
    step(0, 1, 2'b01);
    step(0, 1, 2'b10);
    chk("sat_c1", int'(c_sat), 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 2'b01);
      step(0, 1, 2'b10);
      chk($sformatf("sat_c%0d", i + 2), int'(c_sat), (i < 1) ? 2 : 3);
      chk($sformatf("sat_m%0d", i + 2), int'(m_sat), 1);
    end
    step(1, 1, 2'b01);
    chk("clr_p_sat", int'(p_sat), 0);
    chk("clr_c_sat", int'(c_sat), 0);

    // single repeated symbol: N -> N still counts
    step(0, 1, 2'b11);
    chk("rep_p1", int'(p_rep), 1);
    step(0, 1, 2'b11);
    chk("rep_c1", int'(c_rep), 1);
    step(0, 1, 2'b11);
    chk("rep_m2", int'(m_rep), 1);
    chk("rep_c2", int'(c_rep), 2);
    step(0, 0, 2'b11);
    chk("rep_hold", int'(c_rep), 2);
    step(0, 1, 2'b00);
    chk("rep_p0", int'(p_rep), 0);

    // randomized stream
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
